// File: rtl/stream_mux_if.sv
//------------------------------------------------------------------------------
// stream_mux_if : N-channel input bundle plus single output stream for stream_mux
// Revision      : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface stream_mux_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SW = $clog2(N);

    logic [SW-1:0]      sel;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_chan;
    logic               out_ready;

    modport master (
        output sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

`default_nettype wire

// File: rtl/stream_mux.sv
//------------------------------------------------------------------------------
// stream_mux : N-to-1 valid/ready stream multiplexer with a registered output,
//              select-directed (MODE 0) or round-robin (MODE 1) grant.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = 0
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    stream_mux_if.slave   bus
);
    localparam int SW = $clog2(N);

    logic [SW-1:0]    grant;
    logic             grant_valid;
    logic             grant_in_valid;
    logic [WIDTH-1:0] grant_data;
    logic [N-1:0]     in_ready;
    logic             load_en;
    logic             xfer;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SW-1:0]    chan_q,  chan_d;

    assign load_en = !valid_q || bus.out_ready;

    generate
        if (MODE == 1) begin : g_rr
            logic [SW-1:0] ptr_q, ptr_d;
            logic [SW-1:0] hi_grant, lo_grant;
            logic          hi_found, lo_found;

            // Wrapping search = first requester at/above ptr, else lowest overall.
            always_comb begin
                hi_grant = '0;
                hi_found = 1'b0;
                lo_grant = '0;
                lo_found = 1'b0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (bus.in_valid[i]) begin
                        lo_grant = SW'(i);
                        lo_found = 1'b1;
                        if (SW'(i) >= ptr_q) begin
                            hi_grant = SW'(i);
                            hi_found = 1'b1;
                        end
                    end
                end
                grant       = hi_found ? hi_grant : lo_grant;
                grant_valid = hi_found || lo_found;
            end

            always_comb begin
                ptr_d = ptr_q;
                if (xfer) begin
                    ptr_d = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end
        end else begin : g_sel
            always_comb begin
                grant       = bus.sel;
                grant_valid = (int'(bus.sel) < N);
            end
        end
    endgenerate

    always_comb begin
        in_ready       = '0;
        grant_data     = '0;
        grant_in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant == SW'(i)) begin
                grant_data     = bus.in_data[i*WIDTH +: WIDTH];
                grant_in_valid = bus.in_valid[i];
                in_ready[i]    = rst_n && load_en && grant_valid;
            end
        end
    end

    assign xfer = rst_n && load_en && grant_valid && grant_in_valid;

    always_comb begin
        valid_d = load_en ? xfer : valid_q;
        data_d  = xfer ? grant_data : data_q;
        chan_d  = xfer ? grant : chan_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;

endmodule

`default_nettype wire
